// File: rtl/uart_tx_pkg.sv
// Shared register map, bit positions and FSM state encoding for the UART TX peripheral.
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    localparam logic [1:0] REG_TXD    = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_IRQCLR = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_LEVEL_LSB = 4;
    localparam int STAT_LEVEL_MSB = 8;

    localparam int CTRL_IRQ_EN     = 0;
    localparam int CTRL_PARITY_ODD = 1;

    localparam int IRQCLR_PEND = 0;
    localparam int IRQCLR_OVF  = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_periph_tx_fifo.sv
// Synchronous TX FIFO; a push on full is still taken when a pop happens in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a drain-complete interrupt.
// Define UART_TX_PARITY_EN to add a parity bit (even/odd chosen by CTRL.bit1).
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter int          CLK_HZ     = 25000000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h40000030
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        irqout
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    tx_state_t      state;
    tx_state_t      next_state;
    logic [CW-1:0]  baud_cnt;
    logic           baud_done;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           cnt_clr;
    logic           bit_adv;
    logic           irq_set;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_data;
    logic [LW-1:0]  fifo_level;

    logic           sel;
    logic           bus_wr;
    logic           push;
    logic           ovf_set;
    logic           irq_en;
    logic           irq_pend;
    logic           ovf;
    logic           unused_bits;
`ifdef UART_TX_PARITY_EN
    logic           parity_odd;
    logic           parity_bit;

    assign parity_bit = (^shift_reg) ^ parity_odd;
`endif

    assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
    assign bus_wr      = wr && sel;
    assign push        = bus_wr && (addr[3:2] == REG_TXD);
    assign ovf_set     = push && fifo_full && !fifo_pop;
    assign baud_done   = (baud_cnt == CW'(DIV - 1));
    assign irqout      = irq_pend & irq_en;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // The serial line is decoded from state so an async reset forces it high immediately.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        cnt_clr    = 1'b0;
        bit_adv    = 1'b0;
        irq_set    = 1'b0;
        uart_tx    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = ST_START;
                end
            end
            ST_START: begin
                uart_tx = 1'b0;
                if (baud_done) begin
                    cnt_clr    = 1'b1;
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                uart_tx = shift_reg[bit_cnt];
                if (baud_done) begin
                    cnt_clr = 1'b1;
                    bit_adv = 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        next_state = ST_PARITY;
`else
                        next_state = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                uart_tx = parity_bit;
                if (baud_done) begin
                    cnt_clr    = 1'b1;
                    next_state = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_done) begin
                    cnt_clr = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        next_state = ST_START;
                    end else begin
                        irq_set    = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The shift register holds the byte unshifted; bit_cnt selects the bit on the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (cnt_clr || state == ST_IDLE) baud_cnt <= '0;
            else                             baud_cnt <= baud_cnt + 1'b1;
            if (fifo_pop) begin
                shift_reg <= fifo_data;
                bit_cnt   <= '0;
            end else if (bit_adv) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Set events win over a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en     <= 1'b0;
            irq_pend   <= 1'b0;
            ovf        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_odd <= 1'b0;
`endif
        end else begin
            if (bus_wr && addr[3:2] == REG_CTRL) begin
                irq_en     <= wdata[CTRL_IRQ_EN];
`ifdef UART_TX_PARITY_EN
                parity_odd <= wdata[CTRL_PARITY_ODD];
`endif
            end
            if (irq_set)
                irq_pend <= 1'b1;
            else if (bus_wr && addr[3:2] == REG_IRQCLR && wdata[IRQCLR_PEND])
                irq_pend <= 1'b0;
            if (ovf_set)
                ovf <= 1'b1;
            else if (bus_wr && addr[3:2] == REG_IRQCLR && wdata[IRQCLR_OVF])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && sel) begin
            case (addr[3:2])
                REG_STATUS: begin
                    rdata[STAT_BUSY]                     = (state != ST_IDLE);
                    rdata[STAT_FULL]                     = fifo_full;
                    rdata[STAT_EMPTY]                    = fifo_empty;
                    rdata[STAT_OVF]                      = ovf;
                    rdata[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = 5'(fifo_level);
                end
                REG_CTRL: begin
                    rdata[CTRL_IRQ_EN] = irq_en;
`ifdef UART_TX_PARITY_EN
                    rdata[CTRL_PARITY_ODD] = parity_odd;
`endif
                end
                REG_IRQCLR: begin
                    rdata[IRQCLR_PEND] = irq_pend;
                    rdata[IRQCLR_OVF]  = ovf;
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule
